data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_pkg.sv | 28 ++
 rtl/mem_array.sv | 40 ++++
 rtl/data_mem_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the wait-stated data memory controller.
// Optional access statistics are enabled by defining DATA_MEM_CTRL_STATS_EN.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    FIM    = 2'd2
  } state_e;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned DEPTH_DEF     = 128;
  localparam int unsigned WAIT_CYC_DEF  = 2;
  localparam int unsigned HALT_ADDR_DEF = 255;
  localparam int unsigned WAIT_CNT_W    = 4;
  localparam int unsigned STATS_W       = 16;

  // Index width for the storage array; never narrower than one bit.
  function automatic int unsigned index_width(input int unsigned depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x DATA_W storage: synchronous write, registered read.
// The read register only loads on re_i so it holds the last read word.
module mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned AW     = index_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are deliberately outside the reset domain.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= {DATA_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Wait-stated data memory controller with memory-mapped sticky halt register.
// Define DATA_MEM_CTRL_STATS_EN to add saturating read/write completion counters.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned WAIT_CYC  = WAIT_CYC_DEF,
  parameter int unsigned HALT_ADDR = HALT_ADDR_DEF
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic [ADDR_W-1:0]  endereco,
  input  logic [DATA_W-1:0]  escreveDado,
`ifdef DATA_MEM_CTRL_STATS_EN
  output logic [STATS_W-1:0] numLeituras,
  output logic [STATS_W-1:0] numEscritas,
`endif
  output logic [DATA_W-1:0]  leDado,
  output logic               pronto,
  output logic               ocupado,
  output logic               halt,
  output logic               erroEnd
);

  localparam int unsigned MEM_AW = index_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] HALT_A = ADDR_W'(HALT_ADDR);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYC == 0) ? {WAIT_CNT_W{1'b0}} : WAIT_CNT_W'(WAIT_CYC - 1);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    wr_q, wr_d;

  logic                    pronto_q, erro_q, ocupado_q, halt_q;
  logic                    use_mem_q;
  logic [DATA_W-1:0]       alt_q;

  logic                    enter_fim_s, acc_in_range_s, acc_is_halt_s;
  logic                    fim_in_range_s, fim_is_halt_s;
  logic                    mem_we_s, mem_re_s;
  logic [DATA_W-1:0]       mem_rdata_s;
  logic [DATA_W-1:0]       halt_word_s;

  // State, wait counter and request latches.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {WAIT_CNT_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state logic; a request is only latched while idle, so busy-time requests vanish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (memRead || memWrite) begin
          addr_d  = endereco;
          data_d  = escreveDado;
          wr_d    = memWrite;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYC == 0) ? FIM : ESPERA;
        end else begin
          state_d = IDLE;
        end
      end
      ESPERA: begin
        if (cnt_q == {WAIT_CNT_W{1'b0}}) begin
          state_d = FIM;
        end else begin
          cnt_d = cnt_q - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      FIM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The access is performed on the edge entering FIM; addr_d/wr_d already
  // carry the live request when WAIT_CYC is zero and the latch otherwise.
  always_comb begin
    enter_fim_s    = (state_d == FIM) && (state_q != FIM);
    acc_in_range_s = ({1'b0, addr_d} < DEPTH_A);
    acc_is_halt_s  = (addr_d == HALT_A);
    fim_in_range_s = ({1'b0, addr_q} < DEPTH_A);
    fim_is_halt_s  = (addr_q == HALT_A);
    mem_we_s       = enter_fim_s && wr_d && acc_in_range_s && !reset;
    mem_re_s       = enter_fim_s && !wr_d && acc_in_range_s && !reset;
    halt_word_s    = {{(DATA_W-1){1'b0}}, halt_q};
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .clk_i   (Clock),
    .rst_i   (reset),
    .we_i    (mem_we_s),
    .re_i    (mem_re_s),
    .addr_i  (addr_d[MEM_AW-1:0]),
    .wdata_i (data_d),
    .rdata_o (mem_rdata_s)
  );

  // Status flags, halt register and read-data source selection.
  always_ff @(posedge Clock) begin
    if (reset) begin
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
      halt_q    <= 1'b0;
      use_mem_q <= 1'b0;
      alt_q     <= {DATA_W{1'b0}};
    end else begin
      pronto_q  <= (state_q == FIM);
      erro_q    <= (state_q == FIM) && !fim_in_range_s && !fim_is_halt_s;
      ocupado_q <= (state_d != IDLE);
      if (enter_fim_s && wr_d && acc_is_halt_s) begin
        halt_q <= 1'b1;
      end
      if (enter_fim_s && !wr_d) begin
        use_mem_q <= acc_in_range_s;
        alt_q     <= acc_is_halt_s ? halt_word_s : {DATA_W{1'b0}};
      end
    end
  end

  assign leDado  = use_mem_q ? mem_rdata_s : alt_q;
  assign pronto  = pronto_q;
  assign erroEnd = erro_q;
  assign ocupado = ocupado_q;
  assign halt    = halt_q;

`ifdef DATA_MEM_CTRL_STATS_EN
  logic [STATS_W-1:0] num_lei_q, num_esc_q;

  // Saturating counters of completed in-range accesses.
  always_ff @(posedge Clock) begin
    if (reset) begin
      num_lei_q <= {STATS_W{1'b0}};
      num_esc_q <= {STATS_W{1'b0}};
    end else if ((state_q == FIM) && fim_in_range_s) begin
      if (wr_q) begin
        if (num_esc_q != {STATS_W{1'b1}}) begin
          num_esc_q <= num_esc_q + {{(STATS_W-1){1'b0}}, 1'b1};
        end
      end else begin
        if (num_lei_q != {STATS_W{1'b1}}) begin
          num_lei_q <= num_lei_q + {{(STATS_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign numLeituras = num_lei_q;
  assign numEscritas = num_esc_q;
`endif

endmodule
